// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 SRAM responder.
// States, MMIO address, default waits and the per-state strobe map.
package slc3_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        RD_CAPTURE,
        RD_RELEASE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        WR_RELEASE
    } mem_state_t;

    localparam logic [15:0] MMIO_ADDR   = 16'hFFFF;
    localparam int          RD_WAIT_DEF = 1;
    localparam int          WR_WAIT_DEF = 2;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic dq_oe;
    } strobe_t;

    // Pin levels to present while in state s; bypass keeps SRAM untouched.
    function automatic strobe_t strobes_for(mem_state_t s, logic bypass);
        strobe_t r;
        r = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
        case (s)
            RD_ACCESS: begin
                r.ce_n = 1'b0;
                r.oe_n = 1'b0;
            end
            RD_CAPTURE: begin
                r.ce_n = bypass;
                r.oe_n = bypass;
            end
            WR_SETUP, WR_HOLD: begin
                r.ce_n  = 1'b0;
                r.dq_oe = 1'b1;
            end
            WR_PULSE: begin
                r.ce_n  = 1'b0;
                r.we_n  = 1'b0;
                r.dq_oe = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// CPU-side request bus and SRAM pin bundle of the responder.
// slave = responder side, master = control unit plus board SRAM.
interface sram_responder_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              Mem_OE;
    logic              Mem_WE;
    logic [15:0]       MAR;
    logic [DATA_W-1:0] MDR_out;
    logic [DATA_W-1:0] Data_to_CPU;
    logic              Rd_valid;
    logic              Busy;
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] Hex_out;
    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_CE_N;
    logic              SRAM_OE_N;
    logic              SRAM_WE_N;
    logic              SRAM_UB_N;
    logic              SRAM_LB_N;
    logic [DATA_W-1:0] SRAM_DQ_out;
    logic              SRAM_DQ_oe;
    logic [DATA_W-1:0] SRAM_DQ_in;

    modport slave (
        input  Mem_OE, Mem_WE, MAR, MDR_out, Switches, SRAM_DQ_in,
        output Data_to_CPU, Rd_valid, Busy, Hex_out, SRAM_ADDR,
        output SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        output SRAM_DQ_out, SRAM_DQ_oe
    );

    modport master (
        output Mem_OE, Mem_WE, MAR, MDR_out, Switches, SRAM_DQ_in,
        input  Data_to_CPU, Rd_valid, Busy, Hex_out, SRAM_ADDR,
        input  SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N,
        input  SRAM_DQ_out, SRAM_DQ_oe
    );
endinterface

// File: rtl/mem_wait_counter.sv
// Loadable 3-bit down-counter; done is high in the last wait cycle.
// Shared by the read access and write pulse waits.
module mem_wait_counter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    output logic       done_o
);
    logic [2:0] cnt_q;

    // Reload on state entry, otherwise count down and stop at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 3'd0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    assign done_o = (cnt_q <= 3'd1);
endmodule

// File: rtl/sram_responder.sv
// SLC-3 memory responder: sequences an async SRAM for Mem_OE/Mem_WE.
// Optional MMIO_SWITCH_EN maps MAR 16'hFFFF to Switches / Hex_out.
module sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input logic              Clk,
    input logic              Reset,
    sram_responder_if.slave  bus
);
    localparam logic [2:0] RD_W = 3'(RD_WAIT);
    localparam logic [2:0] WR_W = 3'(WR_WAIT);

    mem_state_t        state_q, state_d;
    logic              mmio_q, mmio_d;
    strobe_t           stb_q;
    logic              busy_q, rd_valid_q;
    logic [DATA_W-1:0] data_q, dq_out_q;
    logic [ADDR_W-1:0] addr_q;
    logic              cnt_done;
    logic              cnt_load;
    logic [2:0]        cnt_val;
    logic              is_mmio;

`ifdef MMIO_SWITCH_EN
    assign is_mmio = (bus.MAR == MMIO_ADDR);
`else
    assign is_mmio = 1'b0;
`endif

    // Read wait is loaded while idle, write wait while in setup.
    assign cnt_load = (state_q == IDLE) || (state_q == WR_SETUP);
    assign cnt_val  = (state_q == IDLE) ? RD_W : WR_W;

    mem_wait_counter u_wait (
        .clk_i      (Clk),
        .rst_i      (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .done_o     (cnt_done)
    );

    // Next-state selection; write wins when both strobes are high.
    always_comb begin
        state_d = state_q;
        mmio_d  = mmio_q;
        case (state_q)
            IDLE: begin
                if (bus.Mem_WE) begin
                    mmio_d  = is_mmio;
                    state_d = is_mmio ? WR_RELEASE : WR_SETUP;
                end else if (bus.Mem_OE) begin
                    mmio_d  = is_mmio;
                    state_d = is_mmio ? RD_CAPTURE : RD_ACCESS;
                end
            end
            RD_ACCESS:  if (cnt_done) state_d = RD_CAPTURE;
            RD_CAPTURE: state_d = RD_RELEASE;
            RD_RELEASE: if (!bus.Mem_OE) state_d = IDLE;
            WR_SETUP:   state_d = WR_PULSE;
            WR_PULSE:   if (cnt_done) state_d = WR_HOLD;
            WR_HOLD:    state_d = WR_RELEASE;
            WR_RELEASE: if (!bus.Mem_WE) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    // State plus registered pins, all driven from the next state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            mmio_q     <= 1'b0;
            stb_q      <= '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
            busy_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            data_q     <= '0;
            dq_out_q   <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            mmio_q     <= mmio_d;
            stb_q      <= strobes_for(state_d, mmio_d);
            busy_q     <= (state_d != IDLE);
            rd_valid_q <= (state_q == RD_CAPTURE);
            if (state_q == RD_CAPTURE) begin
`ifdef MMIO_SWITCH_EN
                data_q <= mmio_q ? bus.Switches : bus.SRAM_DQ_in;
`else
                data_q <= bus.SRAM_DQ_in;
`endif
            end
            if (state_q == IDLE && (bus.Mem_WE || bus.Mem_OE)) begin
                addr_q <= {{(ADDR_W-16){1'b0}}, bus.MAR};
            end
            if (state_q == IDLE && bus.Mem_WE) begin
                dq_out_q <= bus.MDR_out;
            end
        end
    end

`ifdef MMIO_SWITCH_EN
    logic [DATA_W-1:0] hex_q;

    // Single-cycle MMIO write into the hex display register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hex_q <= '0;
        end else if (state_q == IDLE && bus.Mem_WE && is_mmio) begin
            hex_q <= bus.MDR_out;
        end
    end

    assign bus.Hex_out = hex_q;
`else
    assign bus.Hex_out = '0;
`endif

    assign bus.Data_to_CPU = data_q;
    assign bus.Rd_valid    = rd_valid_q;
    assign bus.Busy        = busy_q;
    assign bus.SRAM_ADDR   = addr_q;
    assign bus.SRAM_CE_N   = stb_q.ce_n;
    assign bus.SRAM_UB_N   = stb_q.ce_n;
    assign bus.SRAM_LB_N   = stb_q.ce_n;
    assign bus.SRAM_OE_N   = stb_q.oe_n;
    assign bus.SRAM_WE_N   = stb_q.we_n;
    assign bus.SRAM_DQ_oe  = stb_q.dq_oe;
    assign bus.SRAM_DQ_out = dq_out_q;
endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder with an async SRAM model.
// Read data goes through a scoreboard queue checked on Rd_valid.
module tb_sram_responder;

    logic Clk;
    logic Reset;

    sram_responder_if bus ();

    sram_responder dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [logic [19:0]];
    int          mem_ver = 0;
    logic [15:0] sb [$];

    int ce_lo = 0;
    int oe_lo = 0;
    int we_lo = 0;
    int rv_n  = 0;

    // Asynchronous SRAM read path.
    always @(bus.SRAM_ADDR or bus.SRAM_CE_N or bus.SRAM_OE_N or mem_ver) begin
        if (bus.SRAM_CE_N === 1'b0 && bus.SRAM_OE_N === 1'b0)
            bus.SRAM_DQ_in = mem.exists(bus.SRAM_ADDR) ? mem[bus.SRAM_ADDR] : 16'h0BAD;
        else
            bus.SRAM_DQ_in = 16'hDEAD;
    end

    // SRAM latches data on the rising edge of WE_N.
    always @(posedge bus.SRAM_WE_N) begin
        if (bus.SRAM_CE_N === 1'b0 && Reset === 1'b0) begin
            mem[bus.SRAM_ADDR] = bus.SRAM_DQ_out;
            mem_ver = mem_ver + 1;
        end
    end

    // Pin monitor and read scoreboard, sampled mid-cycle.
    always @(negedge Clk) begin
        if (bus.SRAM_CE_N === 1'b0) ce_lo = ce_lo + 1;
        if (bus.SRAM_OE_N === 1'b0) oe_lo = oe_lo + 1;
        if (bus.SRAM_WE_N === 1'b0) we_lo = we_lo + 1;
        if (Reset === 1'b0) begin
            checks = checks + 1;
            if ((bus.SRAM_OE_N === 1'b0 && bus.SRAM_DQ_oe === 1'b1) ||
                (bus.SRAM_OE_N === 1'b0 && bus.SRAM_WE_N === 1'b0)) begin
                failures = failures + 1;
                $display("FAIL contention oe_n=%b we_n=%b dq_oe=%b required no overlap",
                         bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_DQ_oe);
            end
        end
        if (bus.Rd_valid === 1'b1) begin
            rv_n   = rv_n + 1;
            checks = checks + 1;
            if (sb.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_rd_valid data=%h required no pulse",
                         bus.Data_to_CPU);
            end else begin
                logic [15:0] exp;
                exp = sb.pop_front();
                if (bus.Data_to_CPU !== exp) begin
                    failures = failures + 1;
                    $display("FAIL read_data got=%h required=%h", bus.Data_to_CPU, exp);
                end
            end
        end
    end

    task automatic clear_counts();
        ce_lo = 0;
        oe_lo = 0;
        we_lo = 0;
        rv_n  = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset       = 1'b1;
        bus.Mem_OE  = 1'b0;
        bus.Mem_WE  = 1'b0;
        bus.MAR     = 16'h0;
        bus.MDR_out = 16'h0;
        bus.Switches = 16'h00FF;
        idle_cycles(3);
        Reset = 1'b0;
        idle_cycles(2);
        @(negedge Clk);
        checks = checks + 1;
        if ({bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N} !== 5'b11111) begin
            failures = failures + 1;
            $display("FAIL reset_strobes got=%b required=11111",
                     {bus.SRAM_CE_N, bus.SRAM_OE_N, bus.SRAM_WE_N, bus.SRAM_UB_N, bus.SRAM_LB_N});
        end
        checks = checks + 1;
        if ({bus.SRAM_DQ_oe, bus.Busy, bus.Rd_valid} !== 3'b000) begin
            failures = failures + 1;
            $display("FAIL reset_flags got=%b required=000",
                     {bus.SRAM_DQ_oe, bus.Busy, bus.Rd_valid});
        end
        checks = checks + 1;
        if (bus.Data_to_CPU !== 16'h0 || bus.Hex_out !== 16'h0 ||
            bus.SRAM_ADDR !== 20'h0 || bus.SRAM_DQ_out !== 16'h0) begin
            failures = failures + 1;
            $display("FAIL reset_regs data=%h hex=%h addr=%h dq=%h required all zero",
                     bus.Data_to_CPU, bus.Hex_out, bus.SRAM_ADDR, bus.SRAM_DQ_out);
        end
    endtask

    task automatic test_read();
        idle_cycles(1);
        clear_counts();
        sb.push_back(16'hBEEF);
        bus.MAR    = 16'h0042;
        bus.Mem_OE = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        checks = checks + 1;
        if (bus.SRAM_ADDR !== 20'h00042 || bus.SRAM_OE_N !== 1'b0 || bus.Busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL read_access addr=%h oe_n=%b busy=%b required 00042/0/1",
                     bus.SRAM_ADDR, bus.SRAM_OE_N, bus.Busy);
        end
        @(posedge Clk);
        @(negedge Clk);
        checks = checks + 1;
        if (bus.Rd_valid !== 1'b0 || bus.Data_to_CPU !== 16'h0) begin
            failures = failures + 1;
            $display("FAIL read_early rd_valid=%b data=%h required 0/0000",
                     bus.Rd_valid, bus.Data_to_CPU);
        end
        @(posedge Clk);
        #1;
        bus.Mem_OE = 1'b0;
        @(negedge Clk);
        checks = checks + 1;
        if (bus.Rd_valid !== 1'b1 || bus.Data_to_CPU !== 16'hBEEF || bus.SRAM_OE_N !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL read_edge2 rd_valid=%b data=%h oe_n=%b required 1/beef/1",
                     bus.Rd_valid, bus.Data_to_CPU, bus.SRAM_OE_N);
        end
        idle_cycles(3);
        @(negedge Clk);
        checks = checks + 1;
        if (oe_lo !== 2 || rv_n !== 1 || bus.Busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL read_counts oe_lo=%0d rv=%0d busy=%b required 2/1/0",
                     oe_lo, rv_n, bus.Busy);
        end
    endtask

    task automatic run_write(input logic [15:0] addr, input logic [15:0] data,
                             input logic with_oe, input int hold,
                             output int dq_oe_n, output int dq_bad);
        idle_cycles(1);
        clear_counts();
        dq_oe_n     = 0;
        dq_bad      = 0;
        bus.MAR     = addr;
        bus.MDR_out = data;
        bus.Mem_WE  = 1'b1;
        bus.Mem_OE  = with_oe;
        for (int i = 0; i < 10; i++) begin
            @(posedge Clk);
            #1;
            if (i == hold - 1) begin
                bus.Mem_WE = 1'b0;
                bus.Mem_OE = 1'b0;
            end
            @(negedge Clk);
            if (bus.SRAM_DQ_oe === 1'b1) begin
                dq_oe_n = dq_oe_n + 1;
                if (bus.SRAM_DQ_out !== data) dq_bad = dq_bad + 1;
            end
        end
    endtask

    task automatic test_write();
        int dq_oe_n, dq_bad;
        run_write(16'h1234, 16'hA5A5, 1'b0, 5, dq_oe_n, dq_bad);
        checks = checks + 1;
        if (we_lo !== 2) begin
            failures = failures + 1;
            $display("FAIL write_we_width got=%0d required=2", we_lo);
        end
        checks = checks + 1;
        if (dq_oe_n !== 4 || dq_bad !== 0 || oe_lo !== 0) begin
            failures = failures + 1;
            $display("FAIL write_bus dq_oe=%0d bad=%0d oe_lo=%0d required 4/0/0",
                     dq_oe_n, dq_bad, oe_lo);
        end
        checks = checks + 1;
        if (!mem.exists(20'h01234) || mem[20'h01234] !== 16'hA5A5 || bus.Busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL write_mem got=%h busy=%b required=a5a5/0",
                     mem.exists(20'h01234) ? mem[20'h01234] : 16'hxxxx, bus.Busy);
        end
    endtask

    task automatic test_both_strobes();
        int dq_oe_n, dq_bad;
        run_write(16'h0077, 16'h3C3C, 1'b1, 5, dq_oe_n, dq_bad);
        checks = checks + 1;
        if (oe_lo !== 0 || rv_n !== 0 || we_lo !== 2) begin
            failures = failures + 1;
            $display("FAIL both_priority oe_lo=%0d rv=%0d we_lo=%0d required 0/0/2",
                     oe_lo, rv_n, we_lo);
        end
        checks = checks + 1;
        if (!mem.exists(20'h00077) || mem[20'h00077] !== 16'h3C3C) begin
            failures = failures + 1;
            $display("FAIL both_mem got=%h required=3c3c",
                     mem.exists(20'h00077) ? mem[20'h00077] : 16'hxxxx);
        end
    endtask

    task automatic test_dropped_read();
        idle_cycles(1);
        clear_counts();
        sb.push_back(16'h1111);
        bus.MAR    = 16'h0100;
        bus.Mem_OE = 1'b1;
        @(posedge Clk);
        #1;
        bus.Mem_OE = 1'b0;
        idle_cycles(5);
        @(negedge Clk);
        checks = checks + 1;
        if (rv_n !== 1 || oe_lo !== 2 || bus.Busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL dropped_read rv=%0d oe_lo=%0d busy=%b required 1/2/0",
                     rv_n, oe_lo, bus.Busy);
        end
    endtask

    task automatic test_back_to_back();
        idle_cycles(1);
        clear_counts();
        sb.push_back(16'hBEEF);
        bus.MAR    = 16'h0042;
        bus.Mem_OE = 1'b1;
        idle_cycles(7);
        @(negedge Clk);
        checks = checks + 1;
        if (rv_n !== 1 || oe_lo !== 2 || bus.Busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL held_read rv=%0d oe_lo=%0d busy=%b required 1/2/1",
                     rv_n, oe_lo, bus.Busy);
        end
        bus.Mem_OE = 1'b0;
        idle_cycles(2);
        clear_counts();
        sb.push_back(16'h3C3C);
        bus.MAR    = 16'h0077;
        bus.Mem_OE = 1'b1;
        idle_cycles(3);
        bus.Mem_OE = 1'b0;
        idle_cycles(3);
        @(negedge Clk);
        checks = checks + 1;
        if (rv_n !== 1 || bus.Data_to_CPU !== 16'h3C3C) begin
            failures = failures + 1;
            $display("FAIL second_read rv=%0d data=%h required 1/3c3c",
                     rv_n, bus.Data_to_CPU);
        end
    endtask

    task automatic test_mmio();
        int dq_oe_n, dq_bad;
        idle_cycles(1);
        clear_counts();
`ifdef MMIO_SWITCH_EN
        sb.push_back(16'h00FF);
`else
        sb.push_back(16'h7777);
`endif
        bus.MAR    = 16'hFFFF;
        bus.Mem_OE = 1'b1;
        idle_cycles(3);
        bus.Mem_OE = 1'b0;
        idle_cycles(3);
        @(negedge Clk);
        checks = checks + 1;
`ifdef MMIO_SWITCH_EN
        if (ce_lo !== 0 || rv_n !== 1) begin
            failures = failures + 1;
            $display("FAIL mmio_read ce_lo=%0d rv=%0d required 0/1", ce_lo, rv_n);
        end
`else
        if (ce_lo !== 2 || rv_n !== 1) begin
            failures = failures + 1;
            $display("FAIL ffff_read ce_lo=%0d rv=%0d required 2/1", ce_lo, rv_n);
        end
`endif
        run_write(16'hFFFF, 16'h1357, 1'b0, 3, dq_oe_n, dq_bad);
        checks = checks + 1;
`ifdef MMIO_SWITCH_EN
        if (bus.Hex_out !== 16'h1357 || ce_lo !== 0 || dq_oe_n !== 0) begin
            failures = failures + 1;
            $display("FAIL mmio_write hex=%h ce_lo=%0d dq_oe=%0d required 1357/0/0",
                     bus.Hex_out, ce_lo, dq_oe_n);
        end
`else
        if (bus.Hex_out !== 16'h0 || ce_lo !== 4 || mem[20'h0FFFF] !== 16'h1357) begin
            failures = failures + 1;
            $display("FAIL ffff_write hex=%h ce_lo=%0d mem=%h required 0000/4/1357",
                     bus.Hex_out, ce_lo, mem[20'h0FFFF]);
        end
`endif
    endtask

    task automatic test_reset_mid_write();
        idle_cycles(1);
        bus.MAR     = 16'h0200;
        bus.MDR_out = 16'h5555;
        bus.Mem_WE  = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        checks = checks + 1;
        if (bus.SRAM_WE_N !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL mid_pulse we_n=%b required=0", bus.SRAM_WE_N);
        end
        Reset      = 1'b1;
        bus.Mem_WE = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        checks = checks + 1;
        if (bus.SRAM_WE_N !== 1'b1 || bus.SRAM_DQ_oe !== 1'b0 ||
            bus.SRAM_CE_N !== 1'b1 || bus.Busy !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_mid we_n=%b dq_oe=%b ce_n=%b busy=%b required 1/0/1/0",
                     bus.SRAM_WE_N, bus.SRAM_DQ_oe, bus.SRAM_CE_N, bus.Busy);
        end
        Reset = 1'b0;
        clear_counts();
        idle_cycles(3);
        @(negedge Clk);
        checks = checks + 1;
        if (bus.Busy !== 1'b0 || we_lo !== 0 || rv_n !== 0) begin
            failures = failures + 1;
            $display("FAIL after_reset busy=%b we_lo=%0d rv=%0d required 0/0/0",
                     bus.Busy, we_lo, rv_n);
        end
    endtask

    initial begin
        mem[20'h00042] = 16'hBEEF;
        mem[20'h00100] = 16'h1111;
        mem[20'h0FFFF] = 16'h7777;
        test_reset();
        test_read();
        test_write();
        test_both_strobes();
        test_dropped_read();
        test_back_to_back();
        test_mmio();
        test_reset_mid_write();
        checks = checks + 1;
        if (sb.size() != 0) begin
            failures = failures + 1;
            $display("FAIL scoreboard_left got=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 control unit's Mem_OE/Mem_WE strobes.
- Takes MAR address and MDR write data, sequences an external asynchronous 16-bit SRAM with active-low strobes, and returns registered read data to the MDR input mux.
- Read timing is sized so data is stable in the third cycle of a 3-cycle Mem_OE request.
- Sits between the datapath (MAR/MDR) and the board SRAM pins; the tristate buffer lives in the top level.

Parameters:
ADDR_W, 20, SRAM address width; MAR is zero-extended to this width.
DATA_W, 16, data word width.
RD_WAIT, 1, cycles spent in RD_ACCESS before capture (1..7).
WR_WAIT, 2, cycles WE_N is held low (1..7).

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous active-high reset
Mem_OE  in  1  read request level, held by the control unit
Mem_WE  in  1  write request level, held by the control unit
MAR  in  16  word address
MDR_out  in  16  write data
Data_to_CPU  out  16  registered read data
Rd_valid  out  1  one-cycle pulse when Data_to_CPU is updated
Busy  out  1  high in any state other than IDLE
Switches  in  16  board switches (used only with MMIO_SWITCH_EN)
Hex_out  out  16  hex display register
SRAM_ADDR  out  ADDR_W  address to SRAM
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM strobes
SRAM_DQ_out  out  16  write data toward the top-level tristate
SRAM_DQ_oe  out  1  drive enable for the tristate
SRAM_DQ_in  in  16  data from the SRAM pins

Behaviour:
- Single clock Clk; reset is synchronous and active-high on Reset.
- Reset values: all SRAM_*_N = 1, SRAM_DQ_oe = 0, SRAM_ADDR = 0, SRAM_DQ_out = 0, Data_to_CPU = 0, Hex_out = 0, Rd_valid = 0, Busy = 0, state IDLE.
- All outputs are registered. UB_N and LB_N equal CE_N (full-word access only).
- States: IDLE, RD_ACCESS, RD_CAPTURE, RD_RELEASE, WR_SETUP, WR_PULSE, WR_HOLD, WR_RELEASE.
- IDLE:
  - If Mem_WE, latch MAR and MDR_out, go to WR_SETUP.
  - Else if Mem_OE, latch MAR, go to RD_ACCESS.
  - Write has priority when both strobes are high; Mem_OE is then ignored until IDLE is re-entered.
- RD_ACCESS: CE_N = 0, OE_N = 0. Stay RD_WAIT cycles (internal 3-bit counter), then go to RD_CAPTURE.
- RD_CAPTURE: strobes stay asserted. On the exit edge, Data_to_CPU <= SRAM_DQ_in and Rd_valid pulses high for exactly one cycle. Go to RD_RELEASE.
- Read latency: Data_to_CPU is valid RD_WAIT+1 edges after the first edge sampling Mem_OE high (2 edges with the default, i.e. valid during the control unit's third read cycle).
- RD_RELEASE: CE_N = OE_N = 1. Wait until Mem_OE is low, then return to IDLE, so one held request produces exactly one access.
- WR_SETUP: CE_N = 0, WE_N = 1, DQ_oe = 1, one cycle.
- WR_PULSE: WE_N = 0 for WR_WAIT cycles.
- WR_HOLD: WE_N = 1, CE_N = 0, DQ_oe = 1, one cycle (data hold).
- WR_RELEASE: all strobes high, DQ_oe = 0. Wait for Mem_WE low, then go to IDLE.
- SRAM_DQ_oe is never high while SRAM_OE_N is low (no bus contention). OE_N and WE_N are never both low.
- Request dropped mid-access: the sequence completes regardless; RELEASE then exits immediately.
- Reset mid-access: all strobes deassert on that edge; no partial Rd_valid.
- Counter: wait counters reload on state entry; there is no wrap-around path.

Optional Feature:
- Macro MMIO_SWITCH_EN.
- Defined:
  - MAR == 16'hFFFF bypasses the SRAM.
  - A read skips RD_ACCESS, goes to RD_CAPTURE next cycle, and loads Data_to_CPU <= Switches.
  - A write loads Hex_out <= MDR_out in a single cycle, then goes to WR_RELEASE.
  - No SRAM strobe is asserted for either access.
- Undefined: 16'hFFFF is ordinary SRAM, and Hex_out holds 0.

Decomposition:
- Package slc3_mem_pkg holds:
  - the state enum type mem_state_t;
  - localparam MMIO_ADDR = 16'hFFFF;
  - the default wait constants.
- One natural sub-module, mem_wait_counter: a loadable 3-bit down-counter with a done flag, shared by the read and write waits.

Test Plan:
- Reset then idle: all SRAM_*_N = 1, DQ_oe = 0, Busy = 0.
- Read, model returns 16'hBEEF at 0x0042: Mem_OE high for 3 cycles, MAR = 0x0042 -> SRAM_ADDR = 0x00042, OE_N low for 2 cycles, Data_to_CPU = 0xBEEF after edge 2, Rd_valid pulses once.
- Write: Mem_WE high for 5 cycles, MAR = 0x1234, MDR_out = 0xA5A5 -> WE_N low exactly 2 cycles, with DQ_out = 0xA5A5 and DQ_oe = 1 from setup through hold; model memory holds 0xA5A5.
- Simultaneous Mem_OE and Mem_WE -> write sequence runs, no OE_N assertion, no Rd_valid.
- Reset asserted during WR_PULSE -> WE_N = 1, DQ_oe = 0 on the next edge; state IDLE.
- MMIO_SWITCH_EN defined, Switches = 0x00FF: read 0xFFFF returns 0x00FF with no CE_N; write 0x1357 to 0xFFFF sets Hex_out = 0x1357.
